// File: rtl/m_axi_lite_rd_engine.sv
// AXI4-Lite master read engine: command slice onto AR, credit-limited in-order
// responses through a small FIFO, and a sticky watchdog on a stalled slave.
module m_axi_lite_rd_engine #(
  parameter int GLOB_ADDR_WIDTH = 32,
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int OUTSTD_WIDTH    = 2,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [GLOB_ADDR_WIDTH-1:0] cmd_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [GLOB_DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]                 rsp_resp,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clear,
  output logic [GLOB_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY
);

  localparam int DEPTH = 1 << OUTSTD_WIDTH;
  localparam int EW    = GLOB_DATA_WIDTH + 2;
  localparam logic [OUTSTD_WIDTH:0]    CNT_ONE = (OUTSTD_WIDTH+1)'(1);
  localparam logic [OUTSTD_WIDTH:0]    CNT_MAX = (OUTSTD_WIDTH+1)'(DEPTH);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LOAD = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = (TIMEOUT_WIDTH)'(1);

  logic                       ar_valid_q, ar_valid_d;
  logic [GLOB_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [OUTSTD_WIDTH:0]      inflight_q, inflight_d;
  logic [OUTSTD_WIDTH:0]      pending_q, pending_d;
  logic [OUTSTD_WIDTH:0]      wr_ptr_q, wr_ptr_d;
  logic [OUTSTD_WIDTH:0]      rd_ptr_q, rd_ptr_d;
  logic [TIMEOUT_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;
  logic                       err_q, err_d;
  logic [EW-1:0]              mem_q [DEPTH];
  logic [EW-1:0]              mem_d [DEPTH];
  logic [EW-1:0]              head;
  logic fifo_full, fifo_empty, cmd_acc, ar_hs, r_hs, pop, wd_run, wd_fire;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[OUTSTD_WIDTH] != rd_ptr_q[OUTSTD_WIDTH]) &&
                      (wr_ptr_q[OUTSTD_WIDTH-1:0] == rd_ptr_q[OUTSTD_WIDTH-1:0]);

  assign M_AXI_RREADY = !fifo_full && !reset;
  assign cmd_ready    = !reset && !err_q && (!ar_valid_q || M_AXI_ARREADY) &&
                        (inflight_q < CNT_MAX);
  assign cmd_acc = cmd_valid && cmd_ready;
  assign ar_hs   = ar_valid_q && M_AXI_ARREADY;
  assign r_hs    = M_AXI_RVALID && M_AXI_RREADY;
  assign pop     = !fifo_empty && rsp_ready;

  // Down-counter from all-ones; terminal count is the step that lands on zero.
  assign wd_run  = (pending_q != '0) && !r_hs;
  assign wd_fire = wd_run && (wd_cnt_q == WD_ONE);

  assign head          = mem_q[rd_ptr_q[OUTSTD_WIDTH-1:0]];
  assign rsp_valid     = !fifo_empty;
  assign rsp_data      = fifo_empty ? '0 : head[GLOB_DATA_WIDTH-1:0];
  assign rsp_resp      = fifo_empty ? 2'b00 : head[EW-1 -: 2];
  assign busy          = (inflight_q != '0) || ar_valid_q;
  assign err_timeout   = err_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARADDR  = ar_addr_q;

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    if (cmd_acc) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = cmd_addr;
    end else if (ar_hs) begin
      ar_valid_d = 1'b0;
    end

    inflight_d = inflight_q;
    if (cmd_acc && !pop)      inflight_d = inflight_q + CNT_ONE;
    else if (!cmd_acc && pop) inflight_d = inflight_q - CNT_ONE;

    pending_d = pending_q;
    if (ar_hs && !r_hs)      pending_d = pending_q + CNT_ONE;
    else if (!ar_hs && r_hs) pending_d = pending_q - CNT_ONE;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (r_hs) begin
      mem_d[wr_ptr_q[OUTSTD_WIDTH-1:0]] = {M_AXI_RRESP, M_AXI_RDATA};
      wr_ptr_d = wr_ptr_q + CNT_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + CNT_ONE;

    wd_cnt_d = wd_cnt_q;
    if (!wd_run || err_clear) wd_cnt_d = WD_LOAD;
    else if (wd_cnt_q != '0)  wd_cnt_d = wd_cnt_q - WD_ONE;

    // A firing watchdog outranks a simultaneous clear.
    err_d = err_q;
    if (wd_fire)        err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      inflight_q <= '0;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wd_cnt_q   <= WD_LOAD;
      err_q      <= 1'b0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      inflight_q <= inflight_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_m_axi_lite_rd_engine.sv
// Bench for m_axi_lite_rd_engine: directed scenarios plus a random phase, with an
// AXI-Lite slave model and an in-order expected-response queue.
module tb_m_axi_lite_rd_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic          err_timeout, err_clear;
  logic [AW-1:0] cmd_addr, M_AXI_ARADDR;
  logic [DW-1:0] rsp_data, M_AXI_RDATA;
  logic [1:0]    rsp_resp, M_AXI_RRESP;
  logic          M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

  m_axi_lite_rd_engine #(
    .GLOB_ADDR_WIDTH(AW), .GLOB_DATA_WIDTH(DW), .OUTSTD_WIDTH(OW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy),
    .err_timeout(err_timeout), .err_clear(err_clear),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } ar_t;
  ar_t         slv_q[$];
  logic [33:0] exp_q[$];
  logic [31:0] mem  [logic [31:0]];
  logic [1:0]  rmem [logic [31:0]];
  int n_chk = 0, n_fail = 0, cyc = 0, slv_lat = 1, ar_lo_cnt = 0;
  bit slv_hold = 1'b0, ar_rand = 1'b0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes, advance, update models, drive the slave.
  task automatic tick();
    bit          s_rst, s_acc, s_pop, s_arhs, s_rhs;
    logic [31:0] s_addr, s_araddr;
    logic [33:0] e;
    #1;
    s_rst    = reset;
    s_acc    = cmd_valid && cmd_ready;
    s_addr   = cmd_addr;
    s_pop    = rsp_valid && rsp_ready;
    s_arhs   = M_AXI_ARVALID && M_AXI_ARREADY;
    s_araddr = M_AXI_ARADDR;
    s_rhs    = M_AXI_RVALID && M_AXI_RREADY;
    if (!s_rst && exp_q.size() == 4) chk("credit_limit", cmd_ready, 0);
    if (s_pop) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_resp", rsp_resp, e[33:32]);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (s_rst) begin
      exp_q.delete();
      slv_q.delete();
      M_AXI_RVALID = 1'b0;
    end else begin
      if (s_acc) exp_q.push_back({resp_of(s_addr), data_of(s_addr)});
      if (s_rhs) void'(slv_q.pop_front());
      if (s_arhs) slv_q.push_back('{addr: s_araddr, due: cyc - 1 + slv_lat});
      if (!(M_AXI_RVALID && !s_rhs))
        M_AXI_RVALID = (slv_q.size() > 0) && !slv_hold && (slv_q[0].due <= cyc);
    end
    if (M_AXI_RVALID) begin
      M_AXI_RDATA = data_of(slv_q[0].addr);
      M_AXI_RRESP = resp_of(slv_q[0].addr);
    end else begin
      M_AXI_RDATA = '0;
      M_AXI_RRESP = 2'b00;
    end
    if (ar_lo_cnt > 0) begin
      M_AXI_ARREADY = 1'b0;
      ar_lo_cnt--;
    end else begin
      M_AXI_ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input logic [31:0] a);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      acc = cmd_ready;
      tick();
    end
    if (!acc) chk("send_timeout", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 60 && !rsp_valid; i++) tick();
    chk(tag, rsp_valid, 1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && (busy || rsp_valid || exp_q.size() != 0); i++) tick();
    chk("drain_busy", busy, 0);
    chk("drain_rsp_valid", rsp_valid, 0);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_arvalid"}, M_AXI_ARVALID, 0);
    chk({p, "_araddr"}, M_AXI_ARADDR, 0);
    chk({p, "_rready"}, M_AXI_RREADY, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_data"}, rsp_data, 0);
    chk({p, "_rsp_resp"}, rsp_resp, 0);
    chk({p, "_cmd_ready"}, cmd_ready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_timeout, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; rsp_ready = 1'b0; err_clear = 1'b0;
    M_AXI_ARREADY = 1'b1; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    #1;
    chk("post_rst_rready", M_AXI_RREADY, 1);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Single read, slave answers two cycles after AR
    mem[32'h10] = 32'hDEADBEEF;
    slv_lat = 2; rsp_ready = 1'b1;
    send(32'h10);
    chk("single_arvalid", M_AXI_ARVALID, 1);
    chk("single_araddr", M_AXI_ARADDR, 32'h10);
    wait_rsp("single_wait");
    chk("single_data", rsp_data, 32'hDEADBEEF);
    chk("single_resp", rsp_resp, 0);
    tick();
    chk("single_busy", busy, 0);

    // Minimum round trip: 3 cycles from accept to rsp_valid
    slv_lat = 1;
    send(32'h14);
    tick();
    chk("rt_not_yet", rsp_valid, 0);
    tick();
    chk("rt_valid", rsp_valid, 1);
    drain();

    // Back-to-back with a 3-cycle AR stall on the second command
    rsp_ready = 1'b0;
    send(32'h00);
    send(32'h04);
    M_AXI_ARREADY = 1'b0;
    ar_lo_cnt = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_araddr", M_AXI_ARADDR, 32'h04);
      chk("stall_arvalid", M_AXI_ARVALID, 1);
      chk("stall_cmd_ready", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h08;
      tick();
    end
    send(32'h08);
    send(32'h0C);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h20;
    for (int i = 0; i < 6; i++) begin
      chk("fifth_blocked", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("fifth_blocked_pop_cycle", cmd_ready, 0);
    tick();
    chk("fifth_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    drain();

    // Backpressure: 4 responses land while the consumer stalls
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i * 4));
    for (int i = 0; i < 6; i++) begin
      if (M_AXI_RVALID) chk("bp_rready", M_AXI_RREADY, 1);
      if (rsp_valid) chk("bp_head", rsp_data, exp_q[0][31:0]);
      tick();
    end
    chk("bp_valid", rsp_valid, 1);
    chk("bp_full_rready", M_AXI_RREADY, 0);
    chk("bp_head_final", rsp_data, exp_q[0][31:0]);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drained", rsp_valid, 0);
    chk("bp_busy", busy, 0);

    // SLVERR passes through without touching the watchdog
    mem[32'h200] = 32'h0;
    rmem[32'h200] = 2'b10;
    rsp_ready = 1'b0;
    send(32'h200);
    wait_rsp("err_wait");
    chk("err_resp", rsp_resp, 2);
    chk("err_data", rsp_data, 0);
    chk("err_no_timeout", err_timeout, 0);
    drain();

    // Watchdog: fires 15 cycles after the AR handshake with no R beat
    slv_hold = 1'b1;
    send(32'h40);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_not_yet", err_timeout, 0);
    tick();
    chk("wd_fired", err_timeout, 1);
    chk("wd_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h48;
    for (int i = 0; i < 3; i++) begin
      chk("wd_blocked", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    slv_hold = 1'b0;
    wait_rsp("wd_late_wait");
    chk("wd_late_data", rsp_data, data_of(32'h40));
    chk("wd_still_err", err_timeout, 1);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wd_cleared", err_timeout, 0);
    chk("wd_cmd_ready_back", cmd_ready, 1);

    // Timeout firing in the same cycle as err_clear: the set wins
    slv_hold = 1'b1;
    send(32'h44);
    for (int i = 0; i < 15; i++) tick();
    chk("wd2_not_yet", err_timeout, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wd2_set_wins", err_timeout, 1);
    slv_hold = 1'b0;
    drain();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wd2_cleared", err_timeout, 0);

    // Reset with reads outstanding, then a clean read
    mem[32'h300] = 32'h1111_0001;
    mem[32'h304] = 32'h1111_0002;
    mem[32'h308] = 32'h1111_0003;
    rsp_ready = 1'b0;
    send(32'h300);
    send(32'h304);
    send(32'h308);
    tick();
    tick();
    chk("rst2_pre_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst2");
    reset = 1'b0;
    rsp_ready = 1'b1;
    send(32'h10);
    wait_rsp("rst2_read_wait");
    chk("rst2_read_data", rsp_data, 32'hDEADBEEF);
    tick();
    chk("rst2_busy", busy, 0);

    // Random traffic against the expected-response queue
    for (int i = 0; i < 64; i++)
      rmem[32'h1000 + 32'(i * 4)] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    ar_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      rsp_ready = ($urandom_range(0, 3) != 0);
      slv_lat   = $urandom_range(1, 4);
      slv_hold  = ($urandom_range(0, 7) == 0);
      tick();
    end
    ar_rand  = 1'b0;
    slv_hold = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
